forward_history_buffer: RTL
===========================

# forward_history_buffer

Write-side companion of `whole_forward_updater` in the pipelined multi-table cuckoo hash. It records every memory write and every inter-table shift issued by the update stage during the last `FORWARDED_CLOCK_CYCLES` enabled cycles. It presents those records, aged and de-duplicated, as the `forward_*` arrays that the updater uses to correct stale BRAM read data. Newest entries are at index 0.

## Interface
Parameters:
- `DATA_WIDTH`, 4: value width.
- `KEY_WIDTH`, 2: key width.
- `NUMBER_OF_TABLES`, 3: number of hash tables `T`; minimum 2.
- `FORWARDED_CLOCK_CYCLES`, 2: history depth `F`; minimum 1.
- `MAX_HASH_ADR_WIDTH`, 2: stored address width.
- `HASH_TABLE_ADR_WIDTH`, {2,2,2}: per-table address width, each ≤ `MAX_HASH_ADR_WIDTH`.

Ports (`[T]` means unpacked `[NUMBER_OF_TABLES-1:0]`; `[F]` means unpacked `[FORWARDED_CLOCK_CYCLES-1:0]`; `[T-1]` means `[NUMBER_OF_TABLES-2:0]`):
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low (asserted at 0).
- `clk_en`  in  1  pipeline advance enable.
- `flush_i`  in  1  invalidate all history; sampled when `clk_en`=1.
- `wr_valid_i`  in  1 [T]  write to table i this cycle.
- `wr_hash_adr_i`  in  MAX_HASH_ADR_WIDTH [T]  write address.
- `wr_key_i`  in  KEY_WIDTH [T]  written key.
- `wr_data_i`  in  DATA_WIDTH [T]  written data.
- `wr_updated_mem_i`  in  1 [T]  write changes the slot's occupancy (insert/delete, not overwrite).
- `shift_valid_i`  in  1 [T-1]  entry moved from table i to table i+1.
- `shift_hash_adr_i`  in  MAX_HASH_ADR_WIDTH [T-1]  source address in table i.
- `forward_valid_o`  out  1 [F][T]  entry valid and not superseded.
- `forward_hash_adr_o`  out  MAX_HASH_ADR_WIDTH [F][T]
- `forward_key_o`  out  KEY_WIDTH [F][T]
- `forward_data_o`  out  DATA_WIDTH [F][T]
- `forward_updated_mem_o`  out  1 [F][T]
- `forward_shift_valid_o`  out  1 [F][T-1]
- `forward_shift_hash_adr_o`  out  MAX_HASH_ADR_WIDTH [F][T-1]
- `history_fill_o`  out  $clog2(F+1)  number of enabled cycles since reset or flush, saturating at F.

## Operation
- Each table lane is an F-deep shift register of write records. Each shift lane is an F-deep shift register of shift records.
- On an edge with `clk_en`=1, every lane advances:
  - entry k moves to entry k+1;
  - entry F-1 is discarded;
  - the current inputs load entry 0.
- A record with valid=0 is still loaded, so the history always ages.
- Address masking: entry 0 stores `wr_hash_adr_i[i]` with bits ≥ `HASH_TABLE_ADR_WIDTH[i]` forced to 0. The same masking applies to shift addresses, using the source table's width.
- Supersede rule, per table: when the incoming write is valid and an aged entry in the same table has valid=1 and an equal masked address, that entry's valid is cleared on the same edge. As a result, at most one valid entry per (table, address) is ever visible, and it is the newest. Shift lanes are never superseded.
- Flush: `flush_i`=1 with `clk_en`=1 clears every entry at index ≥1. Entry 0 still loads the current inputs, so the current write is kept. `history_fill_o` is set to 1.
- `flush_i` is ignored when `clk_en`=0.
- `history_fill_o` increments on every enabled edge and saturates at F.

## Timing
- Latency: an input sampled at enabled edge n appears at index 0 after edge n and at index k after edge n+k. It is gone after edge n+F.
- `clk_en`=0: all state holds, including fill. Inputs are ignored.
- Reset assertion, asynchronous at any time including mid-stream:
  - every `forward_valid_o`, `forward_shift_valid_o` and `forward_updated_mem_o` bit = 0;
  - all addresses, keys and data = 0;
  - `history_fill_o` = 0.
- After reset release, the first enabled edge loads entry 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Simultaneous flush and supersede: flush takes precedence. Older entries clear regardless of address.

## Structure
- Package `forward_pkg`:
  - `fwd_entry_t` (valid, updated_mem, adr, key, data), using package-level width parameters with per-instance overrides via parameterized typedef use in the module;
  - `fwd_shift_t` (valid, adr);
  - function `mask_adr(adr, width)`.
- Sub-module `forward_history_lane`: one table's F-deep register, supersede compare, and flush. Instantiated T times by a generate loop.
- The shift lanes and the fill counter live in the top module.

## Test plan
- Reset then idle: hold `reset`=0, then release, with `clk_en`=1 and no writes for 3 edges. Required: all outputs 0; `history_fill_o` goes 1, 2, 2.
- Aging: table 1 writes adr 1, key 2, data 3. Required: it appears at `[0][1]` after the edge and at `[1][1]` one edge later, then all table-1 valids are 0 on the following edge.
- Supersede: table 0 writes adr 2, data 5; the next cycle table 0 writes adr 2, data 9. Required: `[0][0]` valid with data 9 and `[1][0]` valid=0. A write to adr 3 instead leaves both entries valid.
- Stall: write, then `clk_en`=0 for 4 cycles while `wr_valid_i` toggles. Required: outputs frozen at their post-write values.
- Flush with write: history full; assert `flush_i` together with a table-2 write to adr 0, data 7. Required: only `[0][2]` valid, with data 7, and `history_fill_o`=1.
- Masking and shift: set `HASH_TABLE_ADR_WIDTH`={2,1,2}; table 1 writes adr 3 while shift 0→1 is issued with adr 2. Required: `forward_hash_adr_o[0][1]`=1, `forward_shift_hash_adr_o[0][0]`=2, and `forward_shift_valid_o[0][0]`=1.

Source files
------------

// File: rtl/forward_history_buffer_pkg.sv
// rtl/forward_history_buffer_pkg.sv - shared types and address masking for the forward history buffer
// Purpose: record layouts for write/shift history entries and the per-table
//          address mask helper used by every lane.
// Ports:   none (package).
package forward_pkg;

    // Widest address the mask helper handles; callers cast in and out of it.
    localparam int FWD_ADR_LIMIT  = 32;
    localparam int FWD_DATA_WIDTH = 4;
    localparam int FWD_KEY_WIDTH  = 2;
    localparam int FWD_ADR_WIDTH  = 2;

    // Default-width record layouts; modules redeclare the same layout
    // locally with their own parameter values.
    typedef struct packed {
        logic                      valid;
        logic                      updated_mem;
        logic [FWD_ADR_WIDTH-1:0]  adr;
        logic [FWD_KEY_WIDTH-1:0]  key;
        logic [FWD_DATA_WIDTH-1:0] data;
    } fwd_entry_t;

    typedef struct packed {
        logic                     valid;
        logic [FWD_ADR_WIDTH-1:0] adr;
    } fwd_shift_t;

    // Zero every address bit at or above the table's real address width.
    function automatic logic [FWD_ADR_LIMIT-1:0] mask_adr(
        input logic [FWD_ADR_LIMIT-1:0] adr,
        input int                       width
    );
        logic [FWD_ADR_LIMIT-1:0] m;
        m = '0;
        for (int b = 0; b < FWD_ADR_LIMIT; b++) begin
            if (b < width) begin
                m[b] = adr[b];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/forward_history_buffer_if.sv
// rtl/forward_history_buffer_if.sv - write/shift request bundle from the update stage
// Purpose: groups the per-table write requests and inter-table shift requests.
// Ports:   master drives wr_* and shift_*; slave (the history buffer) samples them.
interface forward_history_buffer_if #(
    parameter int NUMBER_OF_TABLES   = 3,
    parameter int MAX_HASH_ADR_WIDTH = 2,
    parameter int KEY_WIDTH          = 2,
    parameter int DATA_WIDTH         = 4
);
    logic                          wr_valid_i       [NUMBER_OF_TABLES-1:0];
    logic [MAX_HASH_ADR_WIDTH-1:0] wr_hash_adr_i    [NUMBER_OF_TABLES-1:0];
    logic [KEY_WIDTH-1:0]          wr_key_i         [NUMBER_OF_TABLES-1:0];
    logic [DATA_WIDTH-1:0]         wr_data_i        [NUMBER_OF_TABLES-1:0];
    logic                          wr_updated_mem_i [NUMBER_OF_TABLES-1:0];
    logic                          shift_valid_i    [NUMBER_OF_TABLES-2:0];
    logic [MAX_HASH_ADR_WIDTH-1:0] shift_hash_adr_i [NUMBER_OF_TABLES-2:0];

    modport master (
        output wr_valid_i, wr_hash_adr_i, wr_key_i, wr_data_i, wr_updated_mem_i,
        output shift_valid_i, shift_hash_adr_i
    );

    modport slave (
        input wr_valid_i, wr_hash_adr_i, wr_key_i, wr_data_i, wr_updated_mem_i,
        input shift_valid_i, shift_hash_adr_i
    );
endinterface

// File: rtl/forward_history_buffer_lane.sv
// rtl/forward_history_buffer_lane.sv - one table's aged write history with supersede and flush
// Purpose: DEPTH-deep shift register of write records for a single table.
// Ports:   clk/reset (async active-low), clk_en advance, flush_i, one write
//          request in, DEPTH registered record fields out (index 0 newest).
module forward_history_lane
    import forward_pkg::*;
#(
    parameter int DEPTH         = 2,
    parameter int KEY_WIDTH     = 2,
    parameter int DATA_WIDTH    = 4,
    parameter int ADR_WIDTH     = 2,
    parameter int TBL_ADR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush_i,
    input  logic                  wr_valid_i,
    input  logic [ADR_WIDTH-1:0]  wr_hash_adr_i,
    input  logic [KEY_WIDTH-1:0]  wr_key_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_updated_mem_i,
    output logic                  valid_o       [DEPTH-1:0],
    output logic [ADR_WIDTH-1:0]  adr_o         [DEPTH-1:0],
    output logic [KEY_WIDTH-1:0]  key_o         [DEPTH-1:0],
    output logic [DATA_WIDTH-1:0] data_o        [DEPTH-1:0],
    output logic                  updated_mem_o [DEPTH-1:0]
);

    typedef struct packed {
        logic                  valid;
        logic                  updated_mem;
        logic [ADR_WIDTH-1:0]  adr;
        logic [KEY_WIDTH-1:0]  key;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t               entry_q [DEPTH-1:0];
    entry_t               entry_d [DEPTH-1:0];
    logic [ADR_WIDTH-1:0] masked_adr;

    always_comb begin
        masked_adr = ADR_WIDTH'(mask_adr(FWD_ADR_LIMIT'(wr_hash_adr_i), TBL_ADR_WIDTH));
        entry_d    = entry_q;
        if (clk_en) begin
            entry_d[0].valid       = wr_valid_i;
            entry_d[0].updated_mem = wr_updated_mem_i;
            entry_d[0].adr         = masked_adr;
            entry_d[0].key         = wr_key_i;
            entry_d[0].data        = wr_data_i;
            for (int k = 1; k < DEPTH; k++) begin
                entry_d[k] = entry_q[k-1];
                // Flush wins over supersede: older history is simply dropped.
                if (flush_i) begin
                    entry_d[k] = '0;
                end else if (wr_valid_i && entry_q[k-1].valid &&
                             (entry_q[k-1].adr == masked_adr)) begin
                    // A newer write to the same slot hides the older one.
                    entry_d[k].valid = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

    for (genvar gk = 0; gk < DEPTH; gk++) begin : g_out
        assign valid_o[gk]       = entry_q[gk].valid;
        assign adr_o[gk]         = entry_q[gk].adr;
        assign key_o[gk]         = entry_q[gk].key;
        assign data_o[gk]        = entry_q[gk].data;
        assign updated_mem_o[gk] = entry_q[gk].updated_mem;
    end

endmodule

// File: rtl/forward_history_buffer.sv
// rtl/forward_history_buffer.sv - aged, de-duplicated history of updater writes and shifts
// Purpose: keeps the last FORWARDED_CLOCK_CYCLES enabled cycles of writes
//          (one lane per table) and shifts (one lane per table pair) for
//          forwarding over stale BRAM read data. Index 0 is newest.
// Ports:   clk, reset (async active-low), clk_en, flush_i, wr_if (write and
//          shift requests), forward_* registered history arrays [F][T] /
//          [F][T-1], history_fill_o saturating enabled-cycle count.
module forward_history_buffer
    import forward_pkg::*;
#(
    parameter int DATA_WIDTH             = 4,
    parameter int KEY_WIDTH              = 2,
    parameter int NUMBER_OF_TABLES       = 3,
    parameter int FORWARDED_CLOCK_CYCLES = 2,
    parameter int MAX_HASH_ADR_WIDTH     = 2,
    parameter int HASH_TABLE_ADR_WIDTH [NUMBER_OF_TABLES-1:0] = '{2, 2, 2},
    localparam int FILL_WIDTH = $clog2(FORWARDED_CLOCK_CYCLES + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic                          flush_i,
    forward_history_buffer_if.slave       wr_if,
    output logic                          forward_valid_o          [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0],
    output logic [MAX_HASH_ADR_WIDTH-1:0] forward_hash_adr_o       [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0],
    output logic [KEY_WIDTH-1:0]          forward_key_o            [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0],
    output logic [DATA_WIDTH-1:0]         forward_data_o           [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0],
    output logic                          forward_updated_mem_o    [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-1:0],
    output logic                          forward_shift_valid_o    [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-2:0],
    output logic [MAX_HASH_ADR_WIDTH-1:0] forward_shift_hash_adr_o [FORWARDED_CLOCK_CYCLES-1:0][NUMBER_OF_TABLES-2:0],
    output logic [FILL_WIDTH-1:0]         history_fill_o
);

    localparam int T = NUMBER_OF_TABLES;
    localparam int F = FORWARDED_CLOCK_CYCLES;

    typedef struct packed {
        logic                          valid;
        logic [MAX_HASH_ADR_WIDTH-1:0] adr;
    } shift_t;

    // Per-lane outputs, indexed [table][age] before transposing to [age][table].
    logic                          lane_valid [T-1:0][F-1:0];
    logic [MAX_HASH_ADR_WIDTH-1:0] lane_adr   [T-1:0][F-1:0];
    logic [KEY_WIDTH-1:0]          lane_key   [T-1:0][F-1:0];
    logic [DATA_WIDTH-1:0]         lane_data  [T-1:0][F-1:0];
    logic                          lane_upd   [T-1:0][F-1:0];

    shift_t                shift_q [F-1:0][T-2:0];
    shift_t                shift_d [F-1:0][T-2:0];
    logic [FILL_WIDTH-1:0] fill_q;
    logic [FILL_WIDTH-1:0] fill_d;

    for (genvar gt = 0; gt < T; gt++) begin : g_lane
        forward_history_lane #(
            .DEPTH         (F),
            .KEY_WIDTH     (KEY_WIDTH),
            .DATA_WIDTH    (DATA_WIDTH),
            .ADR_WIDTH     (MAX_HASH_ADR_WIDTH),
            .TBL_ADR_WIDTH (HASH_TABLE_ADR_WIDTH[gt])
        ) u_lane (
            .clk              (clk),
            .reset            (reset),
            .clk_en           (clk_en),
            .flush_i          (flush_i),
            .wr_valid_i       (wr_if.wr_valid_i[gt]),
            .wr_hash_adr_i    (wr_if.wr_hash_adr_i[gt]),
            .wr_key_i         (wr_if.wr_key_i[gt]),
            .wr_data_i        (wr_if.wr_data_i[gt]),
            .wr_updated_mem_i (wr_if.wr_updated_mem_i[gt]),
            .valid_o          (lane_valid[gt]),
            .adr_o            (lane_adr[gt]),
            .key_o            (lane_key[gt]),
            .data_o           (lane_data[gt]),
            .updated_mem_o    (lane_upd[gt])
        );

        for (genvar gk = 0; gk < F; gk++) begin : g_age
            assign forward_valid_o[gk][gt]       = lane_valid[gt][gk];
            assign forward_hash_adr_o[gk][gt]    = lane_adr[gt][gk];
            assign forward_key_o[gk][gt]         = lane_key[gt][gk];
            assign forward_data_o[gk][gt]        = lane_data[gt][gk];
            assign forward_updated_mem_o[gk][gt] = lane_upd[gt][gk];
        end
    end

    // Shift lanes age like write lanes but are never superseded.
    always_comb begin
        shift_d = shift_q;
        fill_d  = fill_q;
        if (clk_en) begin
            for (int j = 0; j < T - 1; j++) begin
                shift_d[0][j].valid = wr_if.shift_valid_i[j];
                // Mask with the source table's width.
                shift_d[0][j].adr   = MAX_HASH_ADR_WIDTH'(mask_adr(
                    FWD_ADR_LIMIT'(wr_if.shift_hash_adr_i[j]), HASH_TABLE_ADR_WIDTH[j]));
            end
            for (int k = 1; k < F; k++) begin
                for (int j = 0; j < T - 1; j++) begin
                    shift_d[k][j] = flush_i ? '0 : shift_q[k-1][j];
                end
            end
            if (flush_i) begin
                fill_d = FILL_WIDTH'(1);
            end else if (fill_q != FILL_WIDTH'(F)) begin
                fill_d = fill_q + FILL_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < F; k++) begin
                for (int j = 0; j < T - 1; j++) begin
                    shift_q[k][j] <= '0;
                end
            end
            fill_q <= '0;
        end else begin
            shift_q <= shift_d;
            fill_q  <= fill_d;
        end
    end

    for (genvar gk = 0; gk < F; gk++) begin : g_shift_age
        for (genvar gj = 0; gj < T - 1; gj++) begin : g_shift_lane
            assign forward_shift_valid_o[gk][gj]    = shift_q[gk][gj].valid;
            assign forward_shift_hash_adr_o[gk][gj] = shift_q[gk][gj].adr;
        end
    end

    assign history_fill_o = fill_q;

endmodule
